// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer definitions for the line rasterizer and the buffer copy
// logic: screen resolution, write-address width, the palette-width helper and
// the rasterizer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int X_RES  = 320;
    localparam int Y_RES  = 240;
    localparam int ADDR_W = $clog2(X_RES * Y_RES);

    // Rasterizer state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_DRAW   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Palette id width: one spare bit above the minimum index width
    function automatic int color_w(input int number_colors);
        return $clog2(number_colors) + 1;
    endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// -----------------------------------------------------------------------------
// line_rasterizer_if
// Request / back-buffer write bundle of the line rasterizer.
//   start, x0, y0, x1, y1, color : draw request (requester -> rasterizer)
//   stall                        : back-buffer write port busy
//   busy, done                   : rasterizer status
//   waddr, din, we               : back-buffer write port
// master = requester side, slave = rasterizer side.
// -----------------------------------------------------------------------------
interface line_rasterizer_if #(
    parameter int COLOR_W = 5,
    parameter int ADDR_W  = fb_pkg::ADDR_W
);
    logic               start;
    logic [8:0]         x0;
    logic [8:0]         x1;
    logic [7:0]         y0;
    logic [7:0]         y1;
    logic [COLOR_W-1:0] color;
    logic               stall;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  waddr;
    logic [COLOR_W-1:0] din;
    logic               we;

    modport master (
        output start, x0, x1, y0, y1, color, stall,
        input  busy, done, waddr, din, we
    );

    modport slave (
        input  start, x0, x1, y0, y1, color, stall,
        output busy, done, waddr, din, we
    );
endinterface

// File: rtl/fb_addr.sv
// -----------------------------------------------------------------------------
// fb_addr
// Column-major frame-buffer address: addr = y + 240*x, built as
// (x<<8) - (x<<4) + y so no multiplier is needed. Shared with the
// front-buffer copy logic, so the 240-row layout is fixed here.
//   x    in  9      column
//   y    in  8      row
//   addr out AW     linear address
// -----------------------------------------------------------------------------
module fb_addr
    import fb_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic [8:0]    x,
    input  logic [7:0]    y,
    output logic [AW-1:0] addr
);

    logic [17:0] x_ext_s;
    logic [17:0] sum_s;

    // 240*x + y via shift-and-subtract; 18 bits covers the largest 9-bit column
    always_comb begin
        x_ext_s = {9'd0, x};
        sum_s   = (x_ext_s << 4'd8) - (x_ext_s << 4'd4) + {10'd0, y};
        addr    = sum_s[AW-1:0];
    end

endmodule

// File: rtl/line_rasterizer.sv
// -----------------------------------------------------------------------------
// line_rasterizer
// Draws one Bresenham line (all octants) into the back buffer, one pixel per
// cycle, honouring a write-port stall and clipping pixels outside the screen.
//   clk   in   1        single clock, rising edge
//   reset in   1        synchronous active-high reset
//   bus   slave         request, status and back-buffer write port
//                       (start, x0..y1, color, stall / busy, done, waddr, din, we)
// Timeline: start sampled in IDLE (cycle 0), SETUP in cycle 1, pixels from
// cycle 2, done pulses the cycle after the last pixel.
// -----------------------------------------------------------------------------
module line_rasterizer #(
    parameter int NUMBER_COLORS = 9,
    parameter int X_RES         = 320,
    parameter int Y_RES         = 240
) (
    input logic              clk,
    input logic              reset,
    line_rasterizer_if.slave bus
);
    import fb_pkg::*;

    localparam int COLOR_W = color_w(NUMBER_COLORS);
    localparam int AW      = $clog2(X_RES * Y_RES);
    localparam logic [9:0] X_LIM = 10'(X_RES);
    localparam logic [8:0] Y_LIM = 9'(Y_RES);

    logic [1:0]          state_r;
    logic [8:0]          x_r;
    logic [8:0]          x1_r;
    logic [7:0]          y_r;
    logic [7:0]          y1_r;
    logic [COLOR_W-1:0]  color_r;
    logic signed [11:0]  dx_r;
    logic signed [11:0]  dy_r;
    logic signed [11:0]  err_r;
    logic                sx_neg_r;
    logic                sy_neg_r;

    logic signed [11:0]  dx_abs_s;
    logic signed [11:0]  dy_abs_s;
    logic signed [11:0]  e2_s;
    logic signed [11:0]  err_step_s;
    logic                step_x_s;
    logic                step_y_s;
    logic [8:0]          x_step_s;
    logic [7:0]          y_step_s;
    logic                last_s;
    logic                emit_s;
    logic                on_screen_s;
    logic [AW-1:0]       addr_s;

    fb_addr #(.AW(AW)) u_fb_addr (
        .x    (x_r),
        .y    (y_r),
        .addr (addr_s)
    );

    // Endpoint distances for SETUP (magnitudes, zero-extended into the error width)
    always_comb begin
        if (x1_r >= x_r) begin
            dx_abs_s = {3'd0, x1_r - x_r};
        end else begin
            dx_abs_s = {3'd0, x_r - x1_r};
        end
        if (y1_r >= y_r) begin
            dy_abs_s = {4'd0, y1_r - y_r};
        end else begin
            dy_abs_s = {4'd0, y_r - y1_r};
        end
    end

    // Bresenham step: both axis decisions use the same e2, so a diagonal move
    // updates x, y and err together
    always_comb begin
        e2_s       = err_r <<< 4'd1;
        step_x_s   = (e2_s >= dy_r);
        step_y_s   = (e2_s <= dx_r);
        err_step_s = err_r + (step_x_s ? dy_r : 12'sd0) + (step_y_s ? dx_r : 12'sd0);
        if (step_x_s) begin
            x_step_s = sx_neg_r ? (x_r - 9'd1) : (x_r + 9'd1);
        end else begin
            x_step_s = x_r;
        end
        if (step_y_s) begin
            y_step_s = sy_neg_r ? (y_r - 8'd1) : (y_r + 8'd1);
        end else begin
            y_step_s = y_r;
        end
        last_s      = (x_r == x1_r) && (y_r == y1_r);
        emit_s      = (state_r == S_DRAW) && !bus.stall;
        on_screen_s = ({1'b0, x_r} < X_LIM) && ({1'b0, y_r} < Y_LIM);
    end

    // Write-port and status decode; reset silences everything in the same cycle
    always_comb begin
        bus.we    = 1'b0;
        bus.waddr = '0;
        bus.din   = '0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        if (!reset) begin
            bus.we   = emit_s && on_screen_s;
            bus.busy = (state_r == S_SETUP) || (state_r == S_DRAW);
            bus.done = (state_r == S_FINISH);
            if (bus.we) begin
                bus.waddr = addr_s;
                bus.din   = color_r;
            end else begin
                bus.waddr = '0;
                bus.din   = '0;
            end
        end else begin
            bus.we   = 1'b0;
            bus.busy = 1'b0;
            bus.done = 1'b0;
        end
    end

    // Control FSM and stepping datapath; stall freezes x, y and err in DRAW
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            x_r      <= 9'd0;
            x1_r     <= 9'd0;
            y_r      <= 8'd0;
            y1_r     <= 8'd0;
            color_r  <= '0;
            dx_r     <= 12'sd0;
            dy_r     <= 12'sd0;
            err_r    <= 12'sd0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        x_r     <= bus.x0;
                        y_r     <= bus.y0;
                        x1_r    <= bus.x1;
                        y1_r    <= bus.y1;
                        color_r <= bus.color;
                        state_r <= S_SETUP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    dx_r     <= dx_abs_s;
                    dy_r     <= -dy_abs_s;
                    err_r    <= dx_abs_s - dy_abs_s;
                    sx_neg_r <= (x1_r < x_r);
                    sy_neg_r <= (y1_r < y_r);
                    state_r  <= S_DRAW;
                end
                S_DRAW: begin
                    if (emit_s) begin
                        if (last_s) begin
                            state_r <= S_FINISH;
                        end else begin
                            x_r   <= x_step_s;
                            y_r   <= y_step_s;
                            err_r <= err_step_s;
                        end
                    end else begin
                        state_r <= S_DRAW;
                    end
                end
                S_FINISH: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// -----------------------------------------------------------------------------
// tb_line_rasterizer
// Self-checking bench: each scenario pushes the expected writes into a
// scoreboard, a negedge monitor pops and compares every write, and the
// scenario task checks timing, counts and status inline.
// -----------------------------------------------------------------------------
module tb_line_rasterizer;

    typedef struct {
        logic [16:0] addr;
        logic [4:0]  din;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    line_rasterizer_if #(.COLOR_W(5), .ADDR_W(17)) bus ();

    line_rasterizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass   = 0;
    int   n_total  = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   first_wr = -1;
    int   wr_cnt   = 0;

    // cycle counter, advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc - t0;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: waddr=%0d din=%0d, required no write", bus.waddr, bus.din);
            end else begin
                mon_e = sb.pop_front();
                if (bus.waddr !== mon_e.addr || bus.din !== mon_e.din)
                    $display("FAIL write_data: waddr=%0d din=%0d, required waddr=%0d din=%0d",
                             bus.waddr, bus.din, mon_e.addr, mon_e.din);
                else
                    n_pass++;
            end
        end
    end

    function automatic exp_t mk(input int a, input int c);
        exp_t e;
        e.addr = 17'(a);
        e.din  = 5'(c);
        return e;
    endfunction

    // Reference Bresenham: pushes on-screen pixels, returns the pixel count
    task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                             input int c, output int n);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        dy  = (y1 >= y0) ? (y0 - y1) : (y1 - y0);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0; y = y0; n = 0;
        while (n < 2000) begin
            if (x < 320 && y < 240) sb.push_back(mk(y + 240 * x, c));
            n++;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1, input int c);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.x0 = 9'(x0); bus.y0 = 8'(y0);
        bus.x1 = 9'(x1); bus.y1 = 8'(y1);
        bus.color = 5'(c);
        t0 = cyc; first_wr = -1; wr_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        while (dcyc < 0 && (cyc - t0) < budget) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcyc = cyc - t0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b1; bus.stall = 1'b1;
        bus.x0 = 9'd1; bus.y0 = 8'd1; bus.x1 = 9'd5; bus.y1 = 8'd5; bus.color = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b, want 0", bus.done); else n_pass++;
        n_total++; if (bus.we !== 1'b0) $display("FAIL reset_we: got %b, want 0", bus.we); else n_pass++;
        n_total++; if (bus.waddr !== 17'd0) $display("FAIL reset_waddr: got %0d, want 0", bus.waddr); else n_pass++;
        n_total++; if (bus.din !== 5'd0) $display("FAIL reset_din: got %0d, want 0", bus.din); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b, want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_horizontal();
        int d;
        sb.push_back(mk(0, 5)); sb.push_back(mk(240, 5));
        sb.push_back(mk(480, 5)); sb.push_back(mk(720, 5));
        issue(0, 0, 3, 0, 5);
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL horiz_busy_c1: got %b, want 1", bus.busy); else n_pass++;
        wait_done(50, d);
        n_total++; if (d !== 6) $display("FAIL horiz_done_cycle: got %0d, want 6", d); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL horiz_busy_at_done: got %b, want 0", bus.busy); else n_pass++;
        n_total++; if (first_wr !== 2) $display("FAIL horiz_first_we: got %0d, want 2", first_wr); else n_pass++;
        n_total++; if (wr_cnt !== 4) $display("FAIL horiz_writes: got %0d, want 4", wr_cnt); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL horiz_left: got %0d, want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_vertical_diag();
        int d;
        sb.push_back(mk(2405, 3)); sb.push_back(mk(2406, 3)); sb.push_back(mk(2407, 3));
        issue(10, 5, 10, 7, 3);
        wait_done(50, d);
        n_total++; if (d !== 5) $display("FAIL vert_done_cycle: got %0d, want 5", d); else n_pass++;
        n_total++; if (wr_cnt !== 3) $display("FAIL vert_writes: got %0d, want 3", wr_cnt); else n_pass++;
        sb.push_back(mk(723, 7)); sb.push_back(mk(482, 7));
        sb.push_back(mk(241, 7)); sb.push_back(mk(0, 7));
        issue(3, 3, 0, 0, 7);
        wait_done(50, d);
        n_total++; if (d !== 6) $display("FAIL diag_done_cycle: got %0d, want 6", d); else n_pass++;
        n_total++; if (wr_cnt !== 4) $display("FAIL diag_writes: got %0d, want 4", wr_cnt); else n_pass++;
    endtask

    task automatic test_single_point();
        int d;
        sb.push_back(mk(76799, 8));
        issue(319, 239, 319, 239, 8);
        wait_done(50, d);
        n_total++; if (d !== 3) $display("FAIL point_done_cycle: got %0d, want 3", d); else n_pass++;
        n_total++; if (wr_cnt !== 1) $display("FAIL point_writes: got %0d, want 1", wr_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        int d, n;
        push_line(0, 0, 5, 2, 9, n);
        issue(0, 0, 5, 2, 9);
        repeat (3) @(posedge clk); #1;
        bus.stall = 1'b1;
        @(negedge clk);
        n_total++; if (bus.we !== 1'b0) $display("FAIL stall_we: got %b, want 0", bus.we); else n_pass++;
        repeat (3) @(posedge clk); #1;
        bus.stall = 1'b0;
        wait_done(50, d);
        n_total++; if (d !== 11) $display("FAIL stall_done_cycle: got %0d, want 11", d); else n_pass++;
        n_total++; if (wr_cnt !== 6) $display("FAIL stall_writes: got %0d, want 6", wr_cnt); else n_pass++;
        n_total++; if (sb.size() !== 0) $display("FAIL stall_left: got %0d, want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int d, n;
        push_line(0, 0, 4, 4, 2, n);
        issue(0, 0, 4, 4, 2);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.x0 = 9'd100; bus.y0 = 8'd100; bus.x1 = 9'd200; bus.y1 = 8'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(50, d);
        n_total++; if (d !== 7) $display("FAIL ignore_done_cycle: got %0d, want 7", d); else n_pass++;
        // start raised during the FINISH cycle must not be taken either
        bus.start = 1'b1; bus.x0 = 9'd50; bus.y0 = 8'd50; bus.x1 = 9'd60; bus.y1 = 8'd60;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL ignore_busy_after: got %b, want 0", bus.busy); else n_pass++;
        n_total++; if (wr_cnt !== 5) $display("FAIL ignore_writes: got %0d, want 5", wr_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        sb.push_back(mk(0, 4)); sb.push_back(mk(240, 4));
        issue(0, 0, 9, 0, 4);
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_total++; if (bus.we !== 1'b0) $display("FAIL rstmid_we: got %b, want 0", bus.we); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b, want 0", bus.busy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        n_total++; if (seen_done !== 1'b0) $display("FAIL rstmid_done: got %b, want 0", seen_done); else n_pass++;
        n_total++; if (wr_cnt !== 2) $display("FAIL rstmid_writes: got %0d, want 2", wr_cnt); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b, want 0", bus.busy); else n_pass++;
        sb.delete();
    endtask

    task automatic test_offscreen();
        int d, n;
        push_line(315, 0, 325, 0, 6, n);
        issue(315, 0, 325, 0, 6);
        wait_done(60, d);
        n_total++; if (d !== 13) $display("FAIL clip_done_cycle: got %0d, want 13", d); else n_pass++;
        n_total++; if (wr_cnt !== 5) $display("FAIL clip_writes: got %0d, want 5", wr_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d, n, x0, y0, x1, y1, c;
        for (int i = 0; i < 8; i++) begin
            x0 = $urandom_range(0, 511); y0 = $urandom_range(0, 255);
            x1 = $urandom_range(0, 511); y1 = $urandom_range(0, 255);
            c  = $urandom_range(0, 31);
            push_line(x0, y0, x1, y1, c, n);
            issue(x0, y0, x1, y1, c);
            wait_done(n + 20, d);
            n_total++;
            if (d !== n + 2)
                $display("FAIL b2b_done_cycle[%0d]: (%0d,%0d)->(%0d,%0d) got %0d, want %0d",
                         i, x0, y0, x1, y1, d, n + 2);
            else n_pass++;
            n_total++; if (sb.size() !== 0) $display("FAIL b2b_left[%0d]: got %0d, want 0", i, sb.size()); else n_pass++;
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical_diag();
        test_single_point();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_offscreen();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter NUMBER_COLORS, default 9: palette size; COLOR_W = $clog2(NUMBER_COLORS)+1 (5 bits at default).
REQ-002 SHALL have parameter X_RES, default 320: horizontal pixels.
REQ-003 SHALL have parameter Y_RES, default 240: vertical pixels; ADDR_W = $clog2(X_RES*Y_RES) (17 at default).
REQ-004 SHALL have port clk  in  1: single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port start  in  1: one-cycle request to draw a line; sampled only in IDLE.
REQ-007 SHALL have ports x0, x1  in  9 each: line endpoint columns.
REQ-008 SHALL have ports y0, y1  in  8 each: line endpoint rows.
REQ-009 SHALL have port color  in  COLOR_W: palette id written to every pixel.
REQ-010 SHALL have port stall  in  1: back-buffer write port busy; freezes stepping.
REQ-011 SHALL have port busy  out  1: high from the cycle after an accepted start until done.
REQ-012 SHALL have port done  out  1: one-cycle pulse on completion.
REQ-013 SHALL have ports waddr  out  ADDR_W, din  out  COLOR_W, we  out  1: back-buffer write port.

Function
REQ-014 SHALL implement states IDLE, SETUP, DRAW, FINISH.
REQ-015 IDLE: on start=1, SHALL latch x0,y0,x1,y1,color and go to SETUP; inputs are ignored otherwise.
REQ-016 SETUP (1 cycle): SHALL compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 by sign, err=dx+dy, then go to DRAW.
REQ-017 DRAW, stall=0: SHALL emit one pixel per cycle: we=1, din=color, waddr=y+Y_RES*x (column-major, matching the front/back buffers).
REQ-018 Stepping SHALL be Bresenham for all octants: with e2=2*err, e2>=dy gives err+=dy, x+=sx; e2<=dx gives err+=dx, y+=sy; both updates apply in the same cycle when both hold.
REQ-019 Error arithmetic SHALL be signed, 12 bits wide, with no overflow at any endpoints in range.
REQ-020 On emitting the pixel where x==x1 and y==y1, SHALL go to FINISH; pixel count = max(dx,|dy|)+1.
REQ-021 DRAW, stall=1: SHALL hold we=0 and freeze x, y and err; the next pixel is emitted the first cycle stall=0.
REQ-022 Pixels with x>=X_RES or y>=Y_RES SHALL be suppressed (we=0) while stepping continues; done still asserts.
REQ-023 FINISH: SHALL pulse done=1 for one cycle, drop busy, and return to IDLE.
REQ-024 Latency: start accepted in cycle 0; first we in cycle 2; with no stall, done arrives in cycle N+2 for N pixels.
REQ-025 A start while busy SHALL be ignored and not queued; start in the FINISH cycle SHALL also be ignored.
REQ-026 A single point (x0==x1, y0==y1) SHALL emit exactly one pixel.
REQ-027 we SHALL be 0 outside DRAW; waddr and din are don't-care when we=0.

Reset
REQ-028 While reset=1 (overriding start and stall), SHALL force IDLE with busy=0, done=0, we=0, waddr=0, din=0.
REQ-029 Reset mid-draw SHALL abort the line, with no further writes from the following cycle and no done pulse.

Structure
REQ-030 Shared package fb_pkg SHALL hold X_RES, Y_RES, ADDR_W, the COLOR_W function and the state enum.
REQ-031 SHALL instantiate sub-module fb_addr: combinational y + Y_RES*x computed as (x<<8)-(x<<4)+y, shared with front-buffer copy logic.

Verification
REQ-032 (0,0)->(3,0), color 5: waddr 0,240,480,720 on 4 consecutive cycles with din=5, done next cycle.
REQ-033 (10,5)->(10,7): waddr 2405,2406,2407; (3,3)->(0,0): waddr 723,482,241,0.
REQ-034 (319,239)->(319,239): exactly one write at waddr 76799, then done.
REQ-035 (0,0)->(5,2) with stall high for 3 cycles after the second pixel: 6 writes total, no duplicates, done at cycle 11.
REQ-036 Start pulsed while busy: ignored; reset asserted after the 2nd pixel of (0,0)->(9,0): we=0 from the next cycle, no done, busy=0.
REQ-037 (315,0)->(325,0): writes only for x=315..319, done after 11 draw cycles.
